game_step_sched: RTL

//  Schedules snake game steps from the periodic game_en tick. Divides game_en by a

---
 rtl/game_step_sched_pkg.sv | 24 ++
 rtl/game_step_sched.sv | 137 +++++++++++++
 2 files changed

// File: rtl/game_step_sched_pkg.sv
// Shared types and helpers for the snake step scheduler.
package game_step_sched_pkg;

  // Scheduler state encoding (matches the shared SCHED_* definitions).
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_PAUSE = 2'd3
  } sched_state_e;

  localparam int unsigned DEF_BASE_TICKS = 8;
  localparam int unsigned DEF_MIN_TICKS  = 1;
  localparam int unsigned DEF_MAX_LEVEL  = 7;

  // Ticks per step: max(base - lvl, min_t), computed without underflow.
  function automatic int unsigned sched_tps(input int unsigned base,
                                            input int unsigned min_t,
                                            input int unsigned lvl);
    if (lvl + min_t >= base) return min_t;
    return base - lvl;
  endfunction

endpackage

// File: rtl/game_step_sched.sv
// Step scheduler: divides game_en by a level-dependent period and
// hands steps to the game core over a req/ack handshake.
module game_step_sched
  import game_step_sched_pkg::*;
#(
  parameter int unsigned BASE_TICKS = DEF_BASE_TICKS,
  parameter int unsigned MIN_TICKS  = DEF_MIN_TICKS,
  parameter int unsigned MAX_LEVEL  = DEF_MAX_LEVEL,
  parameter int unsigned LVL_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_en,
  input  logic             start,
  input  logic             pause_tgl,
  input  logic             game_over,
  input  logic             level_up,
  input  logic             step_ack,
  output logic             step_req,
  output logic             running,
  output logic             paused,
  output logic [LVL_W-1:0] level,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(BASE_TICKS + 1);

  sched_state_e     state_q, state_d;
  logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overrun_q, overrun_d;
  logic             pause_pend_q, pause_pend_d;
  logic             step_req_q, step_req_d;
  logic             running_q, running_d;
  logic             paused_q, paused_d;

  int unsigned      tps;
  logic             fire;

  // Period from the current level; ">=" also catches a count left above
  // the new period after a level_up.
  always_comb begin
    tps  = sched_tps(BASE_TICKS, MIN_TICKS, 32'(level_q));
    fire = (32'(tick_cnt_q) + 32'd1 >= tps);
  end

  // Next-state logic: game_over beats start beats everything else.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    level_d      = level_q;
    overrun_d    = overrun_q;
    pause_pend_d = pause_pend_q;
    step_req_d   = step_req_q;

    if (game_over) begin
      state_d      = S_IDLE;
      step_req_d   = 1'b0;
      tick_cnt_d   = '0;
      pause_pend_d = 1'b0;
    end else if (start) begin
      state_d      = S_RUN;
      step_req_d   = 1'b0;
      tick_cnt_d   = '0;
      level_d      = '0;
      overrun_d    = 1'b0;
      pause_pend_d = 1'b0;
    end else begin
      if (state_q != S_IDLE && level_up && level_q != LVL_W'(MAX_LEVEL))
        level_d = level_q + LVL_W'(1);

      unique case (state_q)
        S_IDLE: ;
        S_RUN: begin
          if (pause_tgl) begin
            state_d = S_PAUSE;  // same-cycle tick is dropped
          end else if (game_en) begin
            if (fire) begin
              tick_cnt_d = '0;
              step_req_d = 1'b1;
              state_d    = S_WAIT;
            end else begin
              tick_cnt_d = tick_cnt_q + CW'(1);
            end
          end
        end
        S_WAIT: begin
          if (game_en) overrun_d = 1'b1;
          if (step_ack) begin
            step_req_d   = 1'b0;
            state_d      = (pause_pend_q || pause_tgl) ? S_PAUSE : S_RUN;
            pause_pend_d = 1'b0;
          end else if (pause_tgl) begin
            pause_pend_d = ~pause_pend_q;
          end
        end
        S_PAUSE: begin
          if (pause_tgl) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end

    running_d = (state_d == S_RUN) || (state_d == S_WAIT);
    paused_d  = (state_d == S_PAUSE);
  end

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      level_q      <= '0;
      overrun_q    <= 1'b0;
      pause_pend_q <= 1'b0;
      step_req_q   <= 1'b0;
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      level_q      <= level_d;
      overrun_q    <= overrun_d;
      pause_pend_q <= pause_pend_d;
      step_req_q   <= step_req_d;
      running_q    <= running_d;
      paused_q     <= paused_d;
    end
  end

  assign step_req = step_req_q;
  assign running  = running_q;
  assign paused   = paused_q;
  assign level    = level_q;
  assign overrun  = overrun_q;

endmodule
